// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares one main-memory port between the L1 I-cache refill
// path and the L1 D-cache refill/write-back path. One requester owns the port
// for a whole block burst, one word per mem_ack, then gets a done pulse.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate winners on contention
// instead of the default fixed D-over-I priority).
module l1_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ready,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int BEAT_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W  = BEAT_W + 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, I_BURST, D_BURST, DONE} state_t;

  state_t                   state;
  logic [ADDR_W-OFF_W-1:0]  base_blk;
  logic [BEAT_W-1:0]        beat;
  logic                     owner_d;
  logic                     grant_d;
  logic                     addr_low_unused;

  // Byte-offset bits inside a block are dropped by the alignment and never used.
  assign addr_low_unused = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  // On contention the side that did not win last time is chosen.
  always_comb begin
    grant_d = d_req & (~i_req | ~last_d);
  end

  // Remember the winner of every grant; starts as I so the first tie goes to D.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      last_d <= 1'b0;
    else if (state == IDLE && (i_req || d_req))
      last_d <= grant_d;
  end
`else
  // Fixed priority: the D side wins any tie.
  always_comb begin
    grant_d = d_req;
  end
`endif

  // Arbitration and burst sequencing; mem_req, mem_we and done are registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      base_blk <= '0;
      beat     <= '0;
      owner_d  <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          i_done <= 1'b0;
          d_done <= 1'b0;
          if (i_req || d_req) begin
            beat    <= '0;
            owner_d <= grant_d;
            mem_req <= 1'b1;
            if (grant_d) begin
              state    <= D_BURST;
              base_blk <= d_addr[ADDR_W-1:OFF_W];
              mem_we   <= d_we;
            end else begin
              state    <= I_BURST;
              base_blk <= i_addr[ADDR_W-1:OFF_W];
              mem_we   <= 1'b0;
            end
          end
        end
        I_BURST, D_BURST: begin
          if (mem_ack) begin
            if (beat == LAST_BEAT) begin
              state   <= DONE;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              i_done  <= ~owner_d;
              d_done  <= owner_d;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          i_done <= 1'b0;
          d_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat address stays inside the aligned block; data paths are direct copies.
  always_comb begin
    mem_addr  = {base_blk, beat, 2'b00};
    mem_wdata = (state == D_BURST && mem_we) ? d_wdata : 32'h0;
    i_ready   = (state == I_BURST) && mem_ack;
    d_ready   = (state == D_BURST) && mem_ack;
    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
  end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Testbench for l1_mem_arbiter: directed requests, a bench memory responder,
// and a scoreboard monitor that checks every beat and done pulse.
module tb_l1_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req, i_ready, i_done;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ready, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] rdata;
    int          gap;
  } beat_t;

  typedef struct {
    logic is_d;
    int   lat;
  } done_t;

  beat_t       sb_q[$];
  done_t       dn_q[$];
  logic        ack_q[$];
  logic [31:0] wtab[4];
  logic [31:0] rd_base = 32'h0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          cyc = 0;
  int          i_req_cyc = 0, d_req_cyc = 0;
  int          i_pend = 0, d_pend = 0;
  int          wr_idx = 0;

  l1_mem_arbiter #(.ADDR_W(32), .BLOCK_WORDS(4)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Free-running clock and cycle counter.
  initial forever #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Bench memory: word value depends on the beat position within the block.
  assign mem_rdata = rd_base + {30'b0, mem_addr[3:2]};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic pushBurst(input logic is_d, input logic [31:0] base, input logic we,
                           input logic [31:0] rdb, input int first_gap, input int nbeats);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.is_d   = is_d;
      b.addr   = base + 32'(4 * k);
      b.we     = we;
      b.wdata  = (is_d && we) ? wtab[k] : 32'h0;
      b.chk_rd = !we;
      b.rdata  = rdb + 32'(k);
      b.gap    = (k == 0) ? first_gap : -1;
      sb_q.push_back(b);
    end
  endtask

  task automatic pushDone(input logic is_d, input int lat);
    done_t d;
    d.is_d = is_d;
    d.lat  = lat;
    dn_q.push_back(d);
  endtask

  task automatic syncInputs();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic is_d, input logic we, input logic [31:0] addr, input int n);
    if (is_d) begin
      d_we = we; d_addr = addr; d_pend = n; wr_idx = 0; d_wdata = wtab[0];
      d_req = 1'b1; d_req_cyc = cyc;
    end else begin
      i_addr = addr; i_pend = n; i_req = 1'b1; i_req_cyc = cyc;
    end
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || dn_q.size() != 0 || i_req || d_req) && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (n >= budget) begin
      chk_cnt++;
      $display("[TB] FAIL drain_timeout: got %0d beats %0d dones pending expected 0", sb_q.size(), dn_q.size());
      sb_q.delete(); dn_q.delete();
      i_req = 1'b0; d_req = 1'b0; i_pend = 0; d_pend = 0;
    end
    repeat (4) @(posedge clock);
  endtask

  task automatic pulseReset();
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
  endtask

  // Memory responder: ack pattern while a burst is active, stray acks when idle.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (mem_req) mem_ack = (ack_q.size() > 0) ? ack_q.pop_front() : 1'b1;
      else         mem_ack = 1'b1;
    end
  end

  // Requesters: advance write data after d_ready, drop or hold req after done.
  initial begin
    logic cdr, cid, cdd;
    forever begin
      @(negedge clock);
      cdr = d_ready; cid = i_done; cdd = d_done;
      @(posedge clock);
      #1;
      if (cdr) begin
        wr_idx++;
        if (wr_idx < 4) d_wdata = wtab[wr_idx];
      end
      if (cid) begin
        i_pend--;
        if (i_pend <= 0) i_req = 1'b0;
      end
      if (cdd) begin
        d_pend--;
        if (d_pend <= 0) d_req = 1'b0;
        wr_idx = 0; d_wdata = wtab[0];
      end
    end
  end

  // Scoreboard monitor: compare every beat, wait-state hold and done pulse.
  initial begin
    beat_t b;
    done_t dd;
    int    gap_cnt = 0, last_gap = 0;
    logic  prev_req = 1'b0;
    forever begin
      @(negedge clock);
      if (mem_req && !prev_req) begin
        last_gap = gap_cnt;
        gap_cnt  = 0;
      end
      if (!mem_req) gap_cnt++;
      prev_req = mem_req;
      if (mem_req && !mem_ack && sb_q.size() > 0) begin
        checkOutput("hold_addr", mem_addr, sb_q[0].addr);
        checkOutput("hold_we", 32'(mem_we), 32'(sb_q[0].we));
        checkOutput("hold_wdata", mem_wdata, sb_q[0].wdata);
      end
      if (i_ready || d_ready) begin
        if (sb_q.size() == 0) begin
          chk_cnt++;
          $display("[TB] FAIL unexpected_ready: got i_ready=%0b d_ready=%0b expected none", i_ready, d_ready);
        end else begin
          b = sb_q.pop_front();
          checkOutput("ready_side", {30'b0, i_ready, d_ready}, b.is_d ? 32'h1 : 32'h2);
          checkOutput("beat_addr", mem_addr, b.addr);
          checkOutput("beat_we", 32'(mem_we), 32'(b.we));
          checkOutput("beat_wdata", mem_wdata, b.wdata);
          if (b.chk_rd) checkOutput("beat_rdata", b.is_d ? d_rdata : i_rdata, b.rdata);
          if (b.gap >= 0) checkOutput("req_gap", 32'(last_gap), 32'(b.gap));
        end
      end
      if (i_done || d_done) begin
        if (dn_q.size() == 0) begin
          chk_cnt++;
          $display("[TB] FAIL unexpected_done: got i_done=%0b d_done=%0b expected none", i_done, d_done);
        end else begin
          dd = dn_q.pop_front();
          checkOutput("done_side", {30'b0, i_done, d_done}, dd.is_d ? 32'h1 : 32'h2);
          if (dd.lat >= 0)
            checkOutput("done_latency", 32'(cyc - (dd.is_d ? d_req_cyc : i_req_cyc)), 32'(dd.lat));
        end
      end
    end
  end

  // Directed test sequence.
  initial begin
    int n;
    wtab = '{32'h11, 32'h22, 32'h33, 32'h44};
    reset = 1'b0; i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = wtab[0];

    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_ready", {30'b0, i_ready, d_ready}, 32'h0);
    checkOutput("rst_done", {30'b0, i_done, d_done}, 32'h0);
    @(negedge clock); reset = 1'b1;

    // I refill alone
    rd_base = 32'hA0;
    pushBurst(1'b0, 32'h1230, 1'b0, 32'hA0, -1, 4);
    pushDone(1'b0, 5);
    syncInputs();
    applyStimulus(1'b0, 1'b0, 32'h0000_1234, 1);
    waitDrain(40);

    // D write-back
    pushBurst(1'b1, 32'h40, 1'b1, 32'h0, -1, 4);
    pushDone(1'b1, 5);
    syncInputs();
    applyStimulus(1'b1, 1'b1, 32'h40, 1);
    waitDrain(40);

    // Wait states on an I refill
    rd_base = 32'h500;
    ack_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    pushBurst(1'b0, 32'h800, 1'b0, 32'h500, -1, 4);
    pushDone(1'b0, 8);
    syncInputs();
    applyStimulus(1'b0, 1'b0, 32'h80C, 1);
    waitDrain(40);

    // Back-to-back D refills
    rd_base = 32'h700;
    pushBurst(1'b1, 32'h300, 1'b0, 32'h700, -1, 4);
    pushBurst(1'b1, 32'h300, 1'b0, 32'h700, 2, 4);
    pushDone(1'b1, 5);
    pushDone(1'b1, -1);
    syncInputs();
    applyStimulus(1'b1, 1'b0, 32'h308, 2);
    waitDrain(60);

    // Reset mid-burst after two beats
    rd_base = 32'h600;
    ack_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    pushBurst(1'b0, 32'h900, 1'b0, 32'h600, -1, 2);
    syncInputs();
    applyStimulus(1'b0, 1'b0, 32'h904, 1);
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) begin
      chk_cnt++;
      $display("[TB] FAIL midburst_timeout: got %0d beats pending expected 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("midrst_mem_req", 32'(mem_req), 32'h0);
    checkOutput("midrst_mem_addr", mem_addr, 32'h0);
    checkOutput("midrst_ready", {30'b0, i_ready, d_ready}, 32'h0);
    checkOutput("midrst_done", {30'b0, i_done, d_done}, 32'h0);
    i_req = 1'b0; i_pend = 0;
    ack_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    pushBurst(1'b0, 32'h900, 1'b0, 32'h600, -1, 4);
    pushDone(1'b0, 5);
    syncInputs();
    applyStimulus(1'b0, 1'b0, 32'h904, 1);
    waitDrain(40);

    // Contention straight after reset, both sides asking for two blocks
    pulseReset();
    rd_base = 32'hC0;
`ifdef ARB_ROUND_ROBIN_EN
    pushBurst(1'b1, 32'h2000, 1'b0, 32'hC0, -1, 4);
    pushBurst(1'b0, 32'h1000, 1'b0, 32'hC0, 2, 4);
    pushBurst(1'b1, 32'h2000, 1'b0, 32'hC0, 2, 4);
    pushBurst(1'b0, 32'h1000, 1'b0, 32'hC0, 2, 4);
    pushDone(1'b1, 5); pushDone(1'b0, -1); pushDone(1'b1, -1); pushDone(1'b0, -1);
`else
    pushBurst(1'b1, 32'h2000, 1'b0, 32'hC0, -1, 4);
    pushBurst(1'b1, 32'h2000, 1'b0, 32'hC0, 2, 4);
    pushBurst(1'b0, 32'h1000, 1'b0, 32'hC0, 2, 4);
    pushBurst(1'b0, 32'h1000, 1'b0, 32'hC0, 2, 4);
    pushDone(1'b1, 5); pushDone(1'b1, -1); pushDone(1'b0, -1); pushDone(1'b0, -1);
`endif
    syncInputs();
    applyStimulus(1'b1, 1'b0, 32'h2004, 2);
    applyStimulus(1'b0, 1'b0, 32'h1008, 2);
    waitDrain(120);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
